pe_spad_load_ctrl: RTL

//  Clocked load sequencer in front of one PE. Accepts 35-bit packets over a valid/ready

---
 rtl/pe_spad_load_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pe_spad_load_ctrl.sv
// Load sequencer in front of one PE: accepts packets, unpacks them into the ifmap and
// filter scratchpads one entry per cycle, starts the PE and waits for its completion.
module pe_spad_load_ctrl #(
   parameter int          NUM_I    = 5,
   parameter int          NUM_F    = 3,
   parameter int          W_F      = 8,
   parameter int          W_PKT    = 35,
   parameter int          AI       = 3,
   parameter int          AF       = 2,
   parameter logic [2:0]  PE_ADDR  = 3'b000,
   parameter logic [2:0]  MEM_SRC  = 3'b100,
   parameter logic [2:0]  DONE_SRC = 3'b011
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pkt_valid,
   input  logic [W_PKT-1:0] pkt_data,
   output logic             pkt_ready,
   input  logic             filt_clr,
   output logic             ifmap_we,
   output logic [AI-1:0]    ifmap_addr,
   output logic             ifmap_wdata,
   output logic             filt_we,
   output logic [AF-1:0]    filt_addr,
   output logic [W_F-1:0]   filt_wdata,
   output logic             start,
   input  logic             pe_done,
   output logic             pe2_done,
   output logic             busy
);
   // state   | meaning
   // S_IDLE  | ready for a packet
   // S_LOAD  | writing entry idx to the scratchpads
   // S_START | one-cycle start pulse to the PE
   // S_WAIT  | PE computing, waiting for pe_done
   // S_DONE  | one-cycle pe2_done pulse
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DONE} state_t;

   localparam int              W_PAY    = W_PKT - 6;
   localparam logic [AI-1:0]   LAST_IDX = AI'(NUM_I - 1);

   state_t             state_q, state_d;
   logic [AI-1:0]      idx_q, idx_d;
   logic [W_PAY-1:0]   pay_q, pay_d;
   logic               filt_wr_q, filt_wr_d;
   logic               filt_loaded_q, filt_loaded_d;
   logic               accept, is_done_pkt;
   logic [2:0]         src;
   logic [2:0]         dest_unused;

   logic               ready_d, busy_d, ifmap_we_d, ifmap_wdata_d;
   logic               filt_we_d, start_d, pe2_done_d;
   logic [AI-1:0]      ifmap_addr_d;
   logic [AF-1:0]      filt_addr_d;
   logic [W_F-1:0]     filt_wdata_d;

   assign accept      = (state_q == S_IDLE) && pkt_valid;
   assign src         = pkt_data[W_PKT-4 -: 3];
   assign dest_unused = pkt_data[W_PKT-1 -: 3];
   assign is_done_pkt = (PE_ADDR == 3'b010) && (src == DONE_SRC) && (pkt_data[7:0] == 8'hFF);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         pay_q         <= '0;
         filt_wr_q     <= 1'b0;
         filt_loaded_q <= 1'b0;
         pkt_ready     <= 1'b1;
         busy          <= 1'b0;
         ifmap_we      <= 1'b0;
         ifmap_addr    <= '0;
         ifmap_wdata   <= 1'b0;
         filt_we       <= 1'b0;
         filt_addr     <= '0;
         filt_wdata    <= '0;
         start         <= 1'b0;
         pe2_done      <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         pay_q         <= pay_d;
         filt_wr_q     <= filt_wr_d;
         filt_loaded_q <= filt_loaded_d;
         pkt_ready     <= ready_d;
         busy          <= busy_d;
         ifmap_we      <= ifmap_we_d;
         ifmap_addr    <= ifmap_addr_d;
         ifmap_wdata   <= ifmap_wdata_d;
         filt_we       <= filt_we_d;
         filt_addr     <= filt_addr_d;
         filt_wdata    <= filt_wdata_d;
         start         <= start_d;
         pe2_done      <= pe2_done_d;
      end
   end

   // Filter-write permission is frozen at accept so a later filt_clr cannot reopen it mid-packet.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      pay_d         = pay_q;
      filt_wr_d     = filt_wr_q;
      filt_loaded_d = filt_loaded_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               pay_d     = pkt_data[W_PAY-1:0];
               idx_d     = '0;
               filt_wr_d = (src == MEM_SRC) && (!filt_loaded_q || filt_clr);
               state_d   = is_done_pkt ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            if (idx_q == LAST_IDX) begin
               state_d = S_START;
               if (filt_wr_q) filt_loaded_d = 1'b1;
            end else begin
               idx_d = idx_q + AI'(1);
            end
         end
         S_START: state_d = S_WAIT;
         S_WAIT:  if (pe_done) state_d = S_IDLE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (filt_clr) filt_loaded_d = 1'b0;
   end

   // Outputs are decoded from next-state values and registered, so they line up with state_q.
   always_comb begin
      ready_d       = (state_d == S_IDLE);
      busy_d        = (state_d != S_IDLE);
      ifmap_we_d    = (state_d == S_LOAD);
      filt_we_d     = ifmap_we_d && filt_wr_d && (idx_d < AI'(NUM_F));
      start_d       = (state_d == S_START);
      pe2_done_d    = (state_d == S_DONE);
      ifmap_addr_d  = ifmap_we_d ? idx_d : '0;
      filt_addr_d   = filt_we_d ? idx_d[AF-1:0] : '0;
      ifmap_wdata_d = 1'b0;
      filt_wdata_d  = '0;
      for (int i = 0; i < NUM_I; i++) begin
         if (ifmap_we_d && (idx_d == AI'(i))) ifmap_wdata_d = pay_d[i];
      end
      for (int k = 0; k < NUM_F; k++) begin
         if (filt_we_d && (idx_d == AI'(k))) filt_wdata_d = pay_d[NUM_I + W_F*k +: W_F];
      end
   end

endmodule
